// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framer: valid/ready word intake through a one-word holding register,
// emitted as start bit, WIDTH data bits, optional even parity and a stop bit at one bit per clock.
module piso_frame_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_sync,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_word;
  logic             hold_valid;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic             parity_bit, parity_nxt;
  logic             load_hold;
  logic             serial_nxt;
  logic             sync_nxt;
  logic             cur_bit;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (LSB_FIRST) return {1'b0, w[WIDTH-1:1]};
    else           return {w[WIDTH-2:0], 1'b0};
  endfunction

  assign cur_bit    = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
  assign data_ready = !hold_valid;

  // Outputs are registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    cnt_nxt    = bit_cnt;
    parity_nxt = parity_bit;
    load_hold  = 1'b0;
    serial_nxt = 1'b1;
    sync_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          load_hold = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        serial_nxt = 1'b0;
        cnt_nxt    = '0;
        state_nxt  = DATA;
      end
      DATA: begin
        serial_nxt = cur_bit;
        sync_nxt   = (bit_cnt == '0);
        shift_nxt  = shift_word(shift_reg);
        if (bit_cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (PARITY_EN) state_nxt = PARITY;
          else           state_nxt = STOP;
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        serial_nxt = parity_bit;
        state_nxt  = STOP;
      end
      STOP: begin
        if (hold_valid) begin
          load_hold = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Parity is captured with the word, since the shift register is consumed by the data bits.
    if (load_hold) begin
      shift_nxt  = hold_word;
      parity_nxt = even_parity(hold_word);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= cnt_nxt;
      parity_bit <= parity_nxt;
      serial_out <= serial_nxt;
      frame_sync <= sync_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Load and accept never coincide: a load needs hold_valid, an accept needs it clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
    end else if (load_hold) begin
      hold_valid <= 1'b0;
    end else if (data_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_word  <= data_in;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: default build (MSB first, parity) and an LSB-first,
// no-parity build, checked against hand-computed bit streams.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_ser, b_ser;
  logic       a_sync, b_sync;
  logic       a_busy, b_busy;

  int vectors;
  int miscompares;

  piso_frame_tx #(.WIDTH(4), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (a_data),
    .data_valid (a_valid),
    .data_ready (a_ready),
    .serial_out (a_ser),
    .frame_sync (a_sync),
    .busy       (a_busy)
  );

  piso_frame_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (b_data),
    .data_valid (b_valid),
    .data_ready (b_ready),
    .serial_out (b_ser),
    .frame_sync (b_sync),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word through an idle DUT; exp bit i is the i-th line bit after the start edge E+2.
  task automatic send_one(input bit use_b, input logic [3:0] w, input logic [7:0] exp, input int nbits);
    step();
    if (use_b) begin b_data = w; b_valid = 1'b1; end
    else       begin a_data = w; a_valid = 1'b1; end
    step();                                        // edge E: accept
    a_valid = 1'b0;
    b_valid = 1'b0;
    check_val("hold_full_ready", use_b ? b_ready : a_ready, 0);
    step();                                        // edge E+1: FSM loads
    check_val("pre_start_busy", use_b ? b_busy : a_busy, 1);
    check_val("pre_start_line", use_b ? b_ser : a_ser, 1);
    for (int i = 0; i < nbits; i++) begin
      step();
      check_val($sformatf("frame_bit%0d", i), use_b ? b_ser : a_ser, exp[i]);
      check_val($sformatf("frame_sync%0d", i), use_b ? b_sync : a_sync, (i == 1) ? 1 : 0);
    end
    step();
    check_val("after_frame_line", use_b ? b_ser : a_ser, 1);
    check_val("after_frame_busy", use_b ? b_busy : a_busy, 0);
  endtask

  // Source keeps data_valid high over three words; the line is decoded like a 4-bit MSB-first SIPO.
  task automatic send_stream(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
    logic [3:0] words [3];
    logic       q [$];
    int         k, run, stall_max, rises, start;
    logic       rd, prev_rd, acc;
    logic [3:0] got;
    words[0] = w0; words[1] = w1; words[2] = w2;
    k = 0; run = 0; stall_max = 0; rises = 0; prev_rd = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (k < 3) begin a_data = words[k]; a_valid = 1'b1; end
      else       a_valid = 1'b0;
      rd  = a_ready;
      acc = a_valid && rd;
      if (a_valid && !rd) run++;
      else                run = 0;
      if (run > stall_max) stall_max = run;
      if (rd && !prev_rd) rises++;
      prev_rd = rd;
      step();
      if (acc) k++;
      q.push_back(a_ser);
    end
    a_valid = 1'b0;
    start = -1;
    for (int i = 0; i < 12; i++)
      if (start < 0 && q[i] == 1'b0) start = i;
    check_val("stream_start_found", (start >= 0) ? 1 : 0, 1);
    if (start < 0) start = 0;
    for (int f = 0; f < 3; f++) begin
      got = '0;
      for (int b = 1; b <= 4; b++) got = {got[2:0], q[start + 7*f + b]};
      check_val($sformatf("stream_start%0d", f), q[start + 7*f], 0);
      check_val($sformatf("stream_word%0d", f), got, words[f]);
      check_val($sformatf("stream_parity%0d", f), q[start + 7*f + 5], ^words[f]);
      check_val($sformatf("stream_stop%0d", f), q[start + 7*f + 6], 1);
    end
    check_val("stream_idle_after", q[start + 21], 1);
    check_val("stream_ready_rises", rises, 3);
    check_val("stream_stall_cycles", stall_max, 6);
  endtask

  int zeros, busys;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a_data = 4'hF; a_valid = 1'b1;
    b_data = 4'hF; b_valid = 1'b1;

    // Reset held with valid asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_line", a_ser, 1);
      check_val("rst_busy", a_busy, 0);
      check_val("rst_sync", a_sync, 0);
      check_val("rst_ready", a_ready, 1);
      check_val("rst_line_b", b_ser, 1);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
    zeros = 0; busys = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_ser == 1'b0) zeros++;
      if (a_busy) busys++;
    end
    check_val("post_rst_no_frame", zeros + busys, 0);

    // 1011 MSB first: 0,1,0,1,1,par=1,1 -> bits[6:0] = 7'b111_1010.
    send_one(1'b0, 4'b1011, 8'h7A, 7);
    // 0110 LSB first, no parity: 0,0,1,1,0,1 -> bits[5:0] = 6'b10_1100.
    send_one(1'b1, 4'b0110, 8'h2C, 6);

    send_stream(4'hA, 4'h5, 4'hF);
    step(); step();
    send_stream(4'h3, 4'h9, 4'h6);
    step(); step();

    // Reset during DATA of 4'hC with 4'h3 waiting in hold.
    a_data = 4'hC; a_valid = 1'b1;
    step();                                        // E0: accept C
    a_data = 4'h3;
    step();                                        // E0+1: load C
    step();                                        // E0+2: accept 3
    a_valid = 1'b0;
    check_val("mid_hold_full", a_ready, 0);
    step();                                        // E0+3: line = bit3
    step();                                        // E0+4: line = bit2
    check_val("mid_bit2", a_ser, 1);
    rst_n = 1'b0;
    step();                                        // E0+5: would show bit1 = 0
    check_val("mid_rst_line", a_ser, 1);
    check_val("mid_rst_busy", a_busy, 0);
    check_val("mid_rst_ready", a_ready, 1);
    check_val("mid_rst_sync", a_sync, 0);
    rst_n = 1'b1;
    zeros = 0; busys = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_ser == 1'b0) zeros++;
      if (a_busy) busys++;
    end
    check_val("mid_rst_no_remnant", zeros, 0);
    check_val("mid_rst_no_busy", busys, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
